calc_op_sequencer: RTL and testbench

// Host-side initiator for the 8-bit accumulator calculator. Queues {opcode, operand} commands
// and drives the calculator's operand bus, one-cycle strobe and 4-bit opcode. After each strobe
// it captures the calculator's result and {overflow,neg,zero} flags and returns them on a

---
 rtl/calc_op_sequencer.sv | 265 ++++++++++++++++++++++++++
 tb/tb_calc_op_sequencer.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_op_sequencer.sv
// ---------------------------------------------------------------------------
// calc_op_sequencer
//
// Host-side initiator for the 8-bit accumulator calculator. Buffers
// {opcode, operand} commands in a small FIFO, issues each one to the
// calculator with a one-cycle strobe, waits SETTLE cycles, captures the
// calculator result and {overflow,neg,zero} flags, and presents them on a
// valid/ready response channel. Opcodes 4'hB and 4'hC are unsupported: they
// are never issued and are answered immediately with rsp_illegal set.
//
// Parameters
//   DEPTH   command FIFO entries (power of 2, >= 2)
//   SETTLE  cycles between strobe and result sampling (>= 1)
//
// Ports
//   clk           in   rising-edge clock
//   rst           in   asynchronous reset, active-high
//   cmd_valid     in   command offered
//   cmd_ready     out  FIFO can accept (not full)
//   cmd_op        in   [3:0] calculator opcode
//   cmd_operand   in   [7:0] operand
//   calc_operand  out  [7:0] to calculator operand input
//   calc_strobe   out  to calculator execute enable (one-cycle pulse)
//   calc_op       out  [3:0] to calculator opcode input
//   calc_result   in   [7:0] calculator accumulator output
//   calc_flags    in   [2:0] calculator {overflow,neg,zero}
//   rsp_valid     out  response held
//   rsp_ready     in   response consumed
//   rsp_result    out  [7:0] captured result
//   rsp_flags     out  [2:0] captured flags
//   rsp_op        out  [3:0] opcode that produced this response
//   rsp_illegal   out  response is for an unsupported opcode
//   busy          out  FSM not idle or FIFO non-empty
// ---------------------------------------------------------------------------
module calc_op_sequencer #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_op,
  input  logic [7:0] cmd_operand,
  output logic [7:0] calc_operand,
  output logic       calc_strobe,
  output logic [3:0] calc_op,
  input  logic [7:0] calc_result,
  input  logic [2:0] calc_flags,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_result,
  output logic [2:0] rsp_flags,
  output logic [3:0] rsp_op,
  output logic       rsp_illegal,
  output logic       busy
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CNT_W = AW + 1;
  localparam int unsigned WC_W  = $clog2(SETTLE) + 1;

  localparam logic [CNT_W-1:0] FULL_CNT    = CNT_W'(DEPTH);
  localparam logic [WC_W-1:0]  SETTLE_LAST = WC_W'(SETTLE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CAPTURE,
    S_HOLD
  } state_e;

  // -------------------------------------------------------------------------
  // Command FIFO
  // -------------------------------------------------------------------------
  logic [11:0]      mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;

  logic       full;
  logic       empty;
  logic       push;
  logic       pop;
  logic [3:0] head_op;
  logic [7:0] head_operand;
  logic       head_illegal;

  always_comb begin
    full         = (count_q == FULL_CNT);
    empty        = (count_q == '0);
    push         = cmd_valid & ~full;
    head_op      = mem_q[rd_ptr_q][11:8];
    head_operand = mem_q[rd_ptr_q][7:0];
    head_illegal = (head_op == 4'hB) || (head_op == 4'hC);
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {cmd_op, cmd_operand};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // -------------------------------------------------------------------------
  // Sequencer FSM
  // -------------------------------------------------------------------------
  state_e          state_q, state_d;
  logic [WC_W-1:0] wait_cnt_q, wait_cnt_d;

  logic [3:0] calc_op_q,      calc_op_d;
  logic [7:0] calc_operand_q, calc_operand_d;
  logic       rsp_valid_q,    rsp_valid_d;
  logic [7:0] rsp_result_q,   rsp_result_d;
  logic [2:0] rsp_flags_q,    rsp_flags_d;
  logic [3:0] rsp_op_q,       rsp_op_d;
  logic       rsp_illegal_q,  rsp_illegal_d;

  // State register (also holds the issue and response registers).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      wait_cnt_q     <= '0;
      calc_op_q      <= '0;
      calc_operand_q <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_result_q   <= '0;
      rsp_flags_q    <= '0;
      rsp_op_q       <= '0;
      rsp_illegal_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      calc_op_q      <= calc_op_d;
      calc_operand_q <= calc_operand_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_result_q   <= rsp_result_d;
      rsp_flags_q    <= rsp_flags_d;
      rsp_op_q       <= rsp_op_d;
      rsp_illegal_q  <= rsp_illegal_d;
    end
  end

  // Next-state logic. The head entry is popped only when leaving IDLE.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    pop        = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = head_illegal ? S_HOLD : S_ISSUE;
        end
      end
      S_ISSUE: begin
        wait_cnt_d = '0;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (wait_cnt_q == SETTLE_LAST) begin
          state_d = S_CAPTURE;
        end else begin
          wait_cnt_d = wait_cnt_q + WC_W'(1);
        end
      end
      S_CAPTURE: begin
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (rsp_valid_q && rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output logic: issue/response register loads plus the decoded outputs.
  // The strobe is decoded from the state so an asynchronous reset drops it
  // immediately.
  always_comb begin
    calc_op_d      = calc_op_q;
    calc_operand_d = calc_operand_q;
    rsp_valid_d    = rsp_valid_q;
    rsp_result_d   = rsp_result_q;
    rsp_flags_d    = rsp_flags_q;
    rsp_op_d       = rsp_op_q;
    rsp_illegal_d  = rsp_illegal_q;
    unique case (state_q)
      S_IDLE: begin
        if (!empty) begin
          if (head_illegal) begin
            // Answered without touching the calculator; result is left as is.
            rsp_valid_d   = 1'b1;
            rsp_illegal_d = 1'b1;
            rsp_flags_d   = '0;
            rsp_op_d      = head_op;
          end else begin
            calc_op_d      = head_op;
            calc_operand_d = head_operand;
          end
        end
      end
      S_CAPTURE: begin
        rsp_valid_d   = 1'b1;
        rsp_illegal_d = 1'b0;
        rsp_result_d  = calc_result;
        rsp_flags_d   = calc_flags;
        rsp_op_d      = calc_op_q;
      end
      S_HOLD: begin
        if (rsp_valid_q && rsp_ready) begin
          rsp_valid_d = 1'b0;
        end
      end
      default: begin
      end
    endcase

    cmd_ready    = ~full;
    calc_strobe  = (state_q == S_ISSUE);
    calc_op      = calc_op_q;
    calc_operand = calc_operand_q;
    rsp_valid    = rsp_valid_q;
    rsp_result   = rsp_result_q;
    rsp_flags    = rsp_flags_q;
    rsp_op       = rsp_op_q;
    rsp_illegal  = rsp_illegal_q;
    busy         = (state_q != S_IDLE) || !empty;
  end

endmodule

// File: tb/tb_calc_op_sequencer.sv
`timescale 1ns/1ps
// Directed testbench for calc_op_sequencer, with a behavioural model of the
// 8-bit accumulator calculator on the calc_* pins.
module tb_calc_op_sequencer;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned SETTLE = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_op;
  logic [7:0] cmd_operand;
  logic [7:0] calc_operand;
  logic       calc_strobe;
  logic [3:0] calc_op;
  logic [7:0] calc_result;
  logic [2:0] calc_flags;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_result;
  logic [2:0] rsp_flags;
  logic [3:0] rsp_op;
  logic       rsp_illegal;
  logic       busy;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  calc_op_sequencer #(.DEPTH(DEPTH), .SETTLE(SETTLE)) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_operand  (cmd_operand),
    .calc_operand (calc_operand),
    .calc_strobe  (calc_strobe),
    .calc_op      (calc_op),
    .calc_result  (calc_result),
    .calc_flags   (calc_flags),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_result   (rsp_result),
    .rsp_flags    (rsp_flags),
    .rsp_op       (rsp_op),
    .rsp_illegal  (rsp_illegal),
    .busy         (busy)
  );

  // Calculator model: 0 load, 1 sub, 2 add, 3 and, 4 or, 5 xor, 9 not.
  logic [7:0] acc_q = 8'h00;
  logic       ov_q  = 1'b0;
  logic [7:0] sum_w, diff_w;

  always_comb begin
    sum_w       = acc_q + calc_operand;
    diff_w      = acc_q - calc_operand;
    calc_result = acc_q;
    calc_flags  = {ov_q, acc_q[7], (acc_q == 8'h00)};
  end

  always @(posedge clk) begin
    if (calc_strobe === 1'b1) begin
      ov_q <= 1'b0;
      case (calc_op)
        4'h0: acc_q <= calc_operand;
        4'h1: begin
          acc_q <= diff_w;
          ov_q  <= (acc_q[7] != calc_operand[7]) && (diff_w[7] != acc_q[7]);
        end
        4'h2: begin
          acc_q <= sum_w;
          ov_q  <= (acc_q[7] == calc_operand[7]) && (sum_w[7] != acc_q[7]);
        end
        4'h3: acc_q <= acc_q & calc_operand;
        4'h4: acc_q <= acc_q | calc_operand;
        4'h5: acc_q <= acc_q ^ calc_operand;
        4'h9: acc_q <= ~acc_q;
        default: acc_q <= acc_q;
      endcase
    end
  end

  // Strobe counter and strobe timestamps (cycle numbers).
  int cyc        = 0;
  int strobe_cnt = 0;
  int st_cyc [64];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (calc_strobe === 1'b1) begin
      st_cyc[strobe_cnt % 64] <= cyc;
      strobe_cnt <= strobe_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] op, input logic [7:0] opnd);
    cmd_valid   = 1'b1;
    cmd_op      = op;
    cmd_operand = opnd;
    check("push_cmd_ready", cmd_ready, 1);
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int max_cyc);
    int n = 0;
    while (rsp_valid !== 1'b1 && n < max_cyc) begin
      step();
      n++;
    end
    check("rsp_wait", rsp_valid, 1);
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  logic [3:0] t3_op  [8] = '{4'h0, 4'h2, 4'h1, 4'h5, 4'h3, 4'h0, 4'h0, 4'h0};
  logic [7:0] t3_opd [8] = '{8'h01, 8'h7F, 8'h80, 8'h3C, 8'h0F, 8'h00, 8'h00, 8'h00};
  logic [7:0] res [8];
  logic [2:0] flg [8];
  logic [3:0] rop [8];
  int s0, n_acc, k, n_v;

  initial begin
    rst         = 1'b1;
    cmd_valid   = 1'b0;
    cmd_op      = '0;
    cmd_operand = '0;
    rsp_ready   = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Reset state
    check("rst_cmd_ready",    cmd_ready, 1);
    check("rst_rsp_valid",    rsp_valid, 0);
    check("rst_strobe",       calc_strobe, 0);
    check("rst_busy",         busy, 0);
    check("rst_calc_op",      calc_op, 0);
    check("rst_calc_operand", calc_operand, 0);
    check("rst_rsp_result",   rsp_result, 0);
    check("rst_rsp_flags",    rsp_flags, 0);
    check("rst_rsp_op",       rsp_op, 0);
    check("rst_rsp_illegal",  rsp_illegal, 0);
    rst = 1'b0;
    step();

    // 1: load 0x05, latency of 4 edges after accept
    s0 = strobe_cnt;
    push(4'h0, 8'h05);
    check("t1_busy", busy, 1);
    step();
    check("t1_strobe_issue", calc_strobe, 1);
    check("t1_calc_op", calc_op, 4'h0);
    check("t1_calc_operand", calc_operand, 8'h05);
    step();
    check("t1_strobe_wait", calc_strobe, 0);
    check("t1_valid_e2", rsp_valid, 0);
    step();
    check("t1_valid_e3", rsp_valid, 0);
    step();
    check("t1_valid_e4", rsp_valid, 1);
    check("t1_result", rsp_result, 8'h05);
    check("t1_flags", rsp_flags, 3'b000);
    check("t1_op", rsp_op, 4'h0);
    check("t1_illegal", rsp_illegal, 0);
    check("t1_strobes", strobe_cnt - s0, 1);
    consume();
    check("t1_valid_cleared", rsp_valid, 0);

    // 2: accumulator to 0, then subtract 1
    push(4'h0, 8'h00);
    wait_rsp(20);
    check("t2_zero_flags", rsp_flags, 3'b001);
    consume();
    push(4'h1, 8'h01);
    wait_rsp(20);
    check("t2_result", rsp_result, 8'hFF);
    check("t2_flags", rsp_flags, 3'b010);
    check("t2_op", rsp_op, 4'h1);
    consume();

    // 3: fill the FIFO with the response channel stalled
    s0    = strobe_cnt;
    n_acc = 0;
    cmd_valid = 1'b1;
    for (int i = 0; i < 8 && cmd_ready === 1'b1; i++) begin
      cmd_op      = t3_op[n_acc];
      cmd_operand = t3_opd[n_acc];
      @(posedge clk);
      n_acc++;
      #1;
    end
    cmd_valid = 1'b0;
    check("t3_accepted", n_acc, DEPTH + 1);
    check("t3_cmd_ready_low", cmd_ready, 0);
    repeat (6) step();
    check("t3_one_strobe", strobe_cnt - s0, 1);
    check("t3_hold_valid", rsp_valid, 1);
    check("t3_hold_busy", busy, 1);
    check("t3_hold_result", rsp_result, 8'h01);
    rsp_ready = 1'b1;
    k = 0;
    for (int i = 0; i < 60 && k < 5; i++) begin
      if (rsp_valid === 1'b1) begin
        res[k] = rsp_result;
        flg[k] = rsp_flags;
        rop[k] = rsp_op;
        k++;
      end
      step();
    end
    rsp_ready = 1'b0;
    check("t3_rsp_count", k, 5);
    check("t3_r0", res[0], 8'h01);  check("t3_f0", flg[0], 3'b000);
    check("t3_r1", res[1], 8'h80);  check("t3_f1", flg[1], 3'b110);
    check("t3_r2", res[2], 8'h00);  check("t3_f2", flg[2], 3'b001);
    check("t3_r3", res[3], 8'h3C);  check("t3_f3", flg[3], 3'b000);
    check("t3_r4", res[4], 8'h0C);  check("t3_f4", flg[4], 3'b000);
    check("t3_op1", rop[1], 4'h2);
    check("t3_op4", rop[4], 4'h3);
    check("t3_total_strobes", strobe_cnt - s0, 5);
    check("t3_idle", busy, 0);

    // 4: unsupported opcodes answered without a strobe
    s0 = strobe_cnt;
    push(4'hB, 8'h33);
    step();
    check("t4_valid", rsp_valid, 1);
    check("t4_illegal", rsp_illegal, 1);
    check("t4_flags", rsp_flags, 3'b000);
    check("t4_op", rsp_op, 4'hB);
    check("t4_result_kept", rsp_result, 8'h0C);
    repeat (4) step();
    check("t4_no_strobe", strobe_cnt - s0, 0);
    check("t4_still_valid", rsp_valid, 1);
    consume();
    push(4'hC, 8'h44);
    wait_rsp(10);
    check("t4c_illegal", rsp_illegal, 1);
    check("t4c_op", rsp_op, 4'hC);
    check("t4c_result_kept", rsp_result, 8'h0C);
    consume();
    check("t4_no_strobe_total", strobe_cnt - s0, 0);

    // 5: reset while waiting for the calculator
    push(4'h2, 8'h01);
    step();
    step();
    check("t5_in_wait_strobe", calc_strobe, 0);
    rst = 1'b1;
    #1;
    check("t5_strobe", calc_strobe, 0);
    check("t5_rsp_valid", rsp_valid, 0);
    check("t5_cmd_ready", cmd_ready, 1);
    check("t5_busy", busy, 0);
    s0 = strobe_cnt;
    @(posedge clk);
    #1;
    rst = 1'b0;
    n_v = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (rsp_valid !== 1'b0) n_v++;
    end
    check("t5_no_response", n_v, 0);
    check("t5_no_strobe", strobe_cnt - s0, 0);
    check("t5_idle", busy, 0);

    // 6: back-to-back commands with the response channel always ready
    rsp_ready = 1'b1;
    s0 = strobe_cnt;
    push(4'h0, 8'h10);
    push(4'h2, 8'h01);
    push(4'h9, 8'h5A);
    k = 0;
    for (int i = 0; i < 60 && k < 3; i++) begin
      if (rsp_valid === 1'b1) begin
        res[k] = rsp_result;
        flg[k] = rsp_flags;
        rop[k] = rsp_op;
        k++;
      end
      step();
    end
    rsp_ready = 1'b0;
    check("t6_rsp_count", k, 3);
    check("t6_strobes", strobe_cnt - s0, 3);
    check("t6_gap01", st_cyc[(s0 + 1) % 64] - st_cyc[s0 % 64], 4 + SETTLE);
    check("t6_gap12", st_cyc[(s0 + 2) % 64] - st_cyc[(s0 + 1) % 64], 4 + SETTLE);
    check("t6_r0", res[0], 8'h10);  check("t6_f0", flg[0], 3'b000);  check("t6_o0", rop[0], 4'h0);
    check("t6_r1", res[1], 8'h11);  check("t6_f1", flg[1], 3'b000);  check("t6_o1", rop[1], 4'h2);
    check("t6_r2", res[2], 8'hEE);  check("t6_f2", flg[2], 3'b010);  check("t6_o2", rop[2], 4'h9);
    check("t6_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, failed);
    $fatal(1, "watchdog");
  end

endmodule
